// File: rtl/wb_sram_target.sv
// Wishbone classic target that bridges a 1 KiB address window onto a single-port SRAM.
// Writes ack two cycles after the request, reads three; out-of-window requests get t_err.
module wb_sram_target #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FC00
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] t_adr,
  input  logic [31:0] t_dat_w,
  output logic [31:0] t_dat_r,
  input  logic        t_cyc,
  input  logic        t_stb,
  input  logic        t_we,
  input  logic [3:0]  t_sel,
  output logic        t_ack,
  output logic        t_err,
  input  logic        t_tga,
  input  logic        t_tgd_w,
  input  logic [3:0]  t_tgc,
  output logic        t_tgd_r,
  output logic        sram_csb,
  output logic        sram_web,
  output logic [3:0]  sram_wmask,
  output logic [7:0]  sram_addr,
  output logic [31:0] sram_dat_w,
  input  logic [31:0] sram_dat_r
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t state;
  logic   is_read;
  logic   aborted;
  logic   unused_tags;

  assign unused_tags = ^{t_tga, t_tgd_w, t_tgc};
  assign t_tgd_r     = 1'b0;

  function automatic logic in_window(input logic [31:0] adr);
    return (adr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      is_read    <= 1'b0;
      aborted    <= 1'b0;
      t_ack      <= 1'b0;
      t_err      <= 1'b0;
      t_dat_r    <= 32'h0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_wmask <= 4'h0;
      sram_addr  <= 8'h0;
      sram_dat_w <= 32'h0;
    end else begin
      // Terminations are single-cycle pulses raised on entry to RESP.
      t_ack <= 1'b0;
      t_err <= 1'b0;
      case (state)
        IDLE: begin
          if (t_cyc && t_stb) begin
            if (in_window(t_adr)) begin
              sram_addr  <= t_adr[9:2];
              sram_dat_w <= t_dat_w;
              sram_wmask <= t_we ? t_sel : 4'h0;
              sram_web   <= ~t_we;
              // An empty byte-select write runs the full handshake but never touches the array.
              sram_csb   <= t_we && (t_sel == 4'h0);
              is_read    <= ~t_we;
              aborted    <= 1'b0;
              state      <= ACCESS;
            end else begin
              t_err <= 1'b1;
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          sram_csb <= 1'b1;
          sram_web <= 1'b1;
          if (is_read) begin
            aborted <= ~t_cyc;
            state   <= WAIT;
          end else if (t_cyc) begin
            t_ack <= 1'b1;
            state <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          // Read data from the SRAM is valid in this cycle; abandoned cycles drop it.
          if (t_cyc && !aborted) begin
            t_dat_r <= sram_dat_r;
            t_ack   <= 1'b1;
            state   <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_target.sv
// Randomised bench for wb_sram_target: a word-array reference model predicts each
// termination, a queue carries predictions to a monitor that checks them as they appear.
module tb_wb_sram_target;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] t_adr, t_dat_w, t_dat_r;
  logic        t_cyc, t_stb, t_we, t_ack, t_err, t_tga, t_tgd_w, t_tgd_r;
  logic [3:0]  t_sel, t_tgc, sram_wmask;
  logic        sram_csb, sram_web;
  logic [7:0]  sram_addr;
  logic [31:0] sram_dat_w, sram_dat_r;

  wb_sram_target dut (
    .clock(clock), .reset_n(reset_n),
    .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel),
    .t_ack(t_ack), .t_err(t_err),
    .t_tga(t_tga), .t_tgd_w(t_tgd_w), .t_tgc(t_tgc), .t_tgd_r(t_tgd_r),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_dat_w(sram_dat_w), .sram_dat_r(sram_dat_r)
  );

  always #5 clock = ~clock;

  // Behavioural SRAM: synchronous, read data valid the cycle after sampling.
  logic [31:0] sram_mem [256];
  always @(posedge clock) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int i = 0; i < 4; i++)
          if (sram_wmask[i]) sram_mem[sram_addr][8*i +: 8] <= sram_dat_w[8*i +: 8];
      end else begin
        sram_dat_r <= sram_mem[sram_addr];
      end
    end
  end

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [256];
  logic [31:0] last_rd;
  int          cyc_cnt = 0;
  int          csb_low_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc_cnt);
  endtask

  // Monitor: every termination must match the oldest outstanding prediction.
  always @(negedge clock) begin
    if (!sram_csb) csb_low_cnt++;
    if (reset_n && (t_ack || t_err)) begin
      if (exp_q.size() == 0) begin
        check("spurious_resp", {30'b0, t_ack, t_err}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack", {31'b0, t_ack}, {31'b0, !mon_e.err});
        check("err", {31'b0, t_err}, {31'b0, mon_e.err});
        check("latency", cyc_cnt, mon_e.cyc);
        check("rdata", t_dat_r, mon_e.data);
      end
    end
  end

  function automatic bit model_in_window(input logic [31:0] adr);
    return adr >= 32'h1000_0000 && adr < 32'h1000_0400;
  endfunction

  function automatic void model_write(input logic [31:0] adr, input logic [31:0] dat,
                                      input logic [3:0] sel);
    for (int i = 0; i < 4; i++)
      if (sel[i]) ref_mem[adr[9:2]][8*i +: 8] = dat[8*i +: 8];
  endfunction

  // Caller is positioned at a falling edge; returns at the falling edge of the next free cycle.
  task automatic do_req(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
    exp_t e;
    int   waitc;
    bit   hit;
    t_cyc = 1'b1; t_stb = 1'b1; t_we = we; t_adr = adr; t_dat_w = dat; t_sel = sel;
    t_tga = 1'($urandom); t_tgd_w = 1'($urandom); t_tgc = 4'($urandom);
    hit = model_in_window(adr);
    if (!hit) begin
      e.err = 1'b1; e.cyc = cyc_cnt + 1;
    end else if (we) begin
      model_write(adr, dat, sel);
      e.err = 1'b0; e.cyc = cyc_cnt + 2;
    end else begin
      last_rd = ref_mem[adr[9:2]];
      e.err = 1'b0; e.cyc = cyc_cnt + 3;
    end
    e.data = last_rd;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (hit) begin
      check("csb_access", {31'b0, sram_csb}, {31'b0, we && sel == 4'h0});
      check("web_access", {31'b0, sram_web}, {31'b0, !we});
      check("addr_access", {24'b0, sram_addr}, {24'b0, adr[9:2]});
      check("wmask_access", {28'b0, sram_wmask}, we ? {28'b0, sel} : 32'h0);
      if (we) check("datw_access", sram_dat_w, dat);
    end else begin
      check("csb_oow", {31'b0, sram_csb}, 32'h1);
    end
    waitc = 0;
    @(negedge clock);
    while (!(t_ack || t_err) && waitc < 10) begin
      @(negedge clock);
      waitc++;
    end
    if (waitc >= 10) begin
      check("resp_timeout", 32'(waitc), 32'h0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    t_cyc = 1'b0; t_stb = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, {31'b0, t_ack}, 32'h0);
    check({tag, "_err"}, {31'b0, t_err}, 32'h0);
    check({tag, "_dat_r"}, t_dat_r, 32'h0);
    check({tag, "_tgd_r"}, {31'b0, t_tgd_r}, 32'h0);
    check({tag, "_csb"}, {31'b0, sram_csb}, 32'h1);
    check({tag, "_web"}, {31'b0, sram_web}, 32'h1);
    check({tag, "_wmask"}, {28'b0, sram_wmask}, 32'h0);
    check({tag, "_addr"}, {24'b0, sram_addr}, 32'h0);
    check({tag, "_dat_w"}, sram_dat_w, 32'h0);
  endtask

  initial begin
    int          csb_before;
    int          drain;
    logic [31:0] adr;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    last_rd = 32'h0;
    reset_n = 1'b0;
    t_cyc = 1'b0; t_stb = 1'b0; t_we = 1'b0; t_adr = 32'h0; t_dat_w = 32'h0;
    t_sel = 4'h0; t_tga = 1'b0; t_tgd_w = 1'b0; t_tgc = 4'h0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset_n = 1'b1;

    // Directed: full-word write, readback, byte-lane merge.
    do_req(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
    do_req(1'b0, 32'h1000_0010, 32'h0, 4'hF);
    check("full_word_readback", t_dat_r, 32'hDEAD_BEEF);
    do_req(1'b1, 32'h1000_0010, 32'h0000_00AA, 4'h1);
    do_req(1'b0, 32'h1000_0010, 32'h0, 4'hF);
    check("byte_merge_readback", t_dat_r, 32'hDEAD_BEAA);

    // Out-of-window read must never assert chip select.
    csb_before = csb_low_cnt;
    do_req(1'b0, 32'h2000_0000, 32'h0, 4'hF);
    check("oow_no_csb", 32'(csb_low_cnt - csb_before), 32'h0);

    // Empty byte-select write: acked, array untouched.
    csb_before = csb_low_cnt;
    do_req(1'b1, 32'h1000_0010, 32'h1111_1111, 4'h0);
    check("sel0_no_csb", 32'(csb_low_cnt - csb_before), 32'h0);

    // Strobe without cycle is not a request.
    csb_before = csb_low_cnt;
    t_stb = 1'b1; t_we = 1'b1; t_adr = 32'h1000_0010; t_sel = 4'hF; t_dat_w = 32'h5555_5555;
    repeat (4) @(negedge clock);
    t_stb = 1'b0;
    @(negedge clock);
    check("stb_only_no_csb", 32'(csb_low_cnt - csb_before), 32'h0);

    // Cycle dropped during ACCESS: write lands, no termination.
    t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b1; t_adr = 32'h1000_0020;
    t_dat_w = 32'h1234_5678; t_sel = 4'hF;
    model_write(32'h1000_0020, 32'h1234_5678, 4'hF);
    @(negedge clock);
    t_cyc = 1'b0; t_stb = 1'b0;
    repeat (3) @(negedge clock);
    do_req(1'b0, 32'h1000_0020, 32'h0, 4'hF);
    check("abort_write_readback", t_dat_r, 32'h1234_5678);

    // Reset pulse while a read sits in WAIT.
    t_cyc = 1'b1; t_stb = 1'b1; t_we = 1'b0; t_adr = 32'h1000_0010; t_sel = 4'hF;
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_values("midreset");
    last_rd = 32'h0;
    @(negedge clock);
    t_cyc = 1'b0; t_stb = 1'b0;
    reset_n = 1'b1;
    do_req(1'b0, 32'h1000_0010, 32'h0, 4'hF);
    check("post_reset_read", t_dat_r, 32'hDEAD_BEAA);

    // Randomised traffic over 16 words plus occasional out-of-window addresses.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0)
        adr = ($urandom_range(0, 1) != 0) ? (32'h1000_0400 + 32'($urandom_range(0, 1023)))
                                          : 32'($urandom);
      else
        adr = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      do_req(1'($urandom), adr, 32'($urandom), 4'($urandom));
    end

    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      @(negedge clock);
      drain++;
    end
    check("outstanding_responses", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
